// File: rtl/arm_pkg.sv
// Shared widths, FSM state encoding and the EXE->MEM payload for the ARM pipeline.
package arm_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_wait_state_e;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [WORD_W-1:0]     alu_res;
    logic [WORD_W-1:0]     val_rm;
    logic [REG_ADDR_W-1:0] dest;
  } exe_mem_t;

endpackage

// File: rtl/mem_wait_watchdog.sv
// Tracks how long the current memory op has been waiting and aborts it after TIMEOUT cycles.
// abort_c is combinational and lands in the same cycle as the offending mem_ready.
module mem_wait_watchdog
  import arm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic mem_ready,
  output logic abort_c,
  output logic mem_err,
  output logic err_sticky
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  mem_wait_state_e  state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             mem_err_nxt, err_sticky_nxt;

  assign abort_c = (TIMEOUT != 0) && mem_op && !mem_ready && (wait_cnt == CNT_W'(LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      mem_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      mem_err    <= mem_err_nxt;
      err_sticky <= err_sticky_nxt;
    end
  end

  // Abort outranks both states; ready in the last allowed cycle is a normal completion.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    mem_err_nxt    = 1'b0;
    err_sticky_nxt = err_sticky;
    if (abort_c) begin
      state_nxt      = IDLE;
      wait_cnt_nxt   = '0;
      mem_err_nxt    = 1'b1;
      err_sticky_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt_nxt = '0;
          if (mem_op && !mem_ready) begin
            state_nxt    = ACCESS;
            wait_cnt_nxt = CNT_W'(1);
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
          end else begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: holds the instruction while data memory is busy, freezes
// upstream stages, bounds each wait via the watchdog and counts stall cycles.
module exe_mem_pipe_reg
  import arm_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [WORD_W-1:0]      alu_res_in,
  input  logic [WORD_W-1:0]      val_Rm_in,
  input  logic [REG_ADDR_W-1:0]  dest_in,
  input  logic                   mem_ready,
  output logic                   wb_en_out,
  output logic                   mem_r_en_out,
  output logic                   mem_w_en_out,
  output logic [WORD_W-1:0]      alu_res_out,
  output logic [WORD_W-1:0]      val_Rm_out,
  output logic [REG_ADDR_W-1:0]  dest_out,
  output logic                   freeze_out,
  output logic                   mem_err,
  output logic                   err_sticky,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  exe_mem_t pipe_q;
  exe_mem_t pipe_in;
  logic     mem_op;
  logic     abort_c;

  assign pipe_in = '{wb_en:    wb_en_in,
                     mem_r_en: mem_r_en_in,
                     mem_w_en: mem_w_en_in,
                     alu_res:  alu_res_in,
                     val_rm:   val_Rm_in,
                     dest:     dest_in};

  assign mem_op     = pipe_q.mem_r_en | pipe_q.mem_w_en;
  assign freeze_out = mem_op & ~mem_ready & ~abort_c;

  mem_wait_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .mem_op     (mem_op),
    .mem_ready  (mem_ready),
    .abort_c    (abort_c),
    .mem_err    (mem_err),
    .err_sticky (err_sticky)
  );

  // Pipeline register: loads every non-frozen edge, including the abort edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else if (!freeze_out) begin
      pipe_q <= pipe_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (freeze_out && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

  // Aborted instruction retires as a bubble: suppress its write-back.
  assign wb_en_out    = pipe_q.wb_en & ~abort_c;
  assign mem_r_en_out = pipe_q.mem_r_en;
  assign mem_w_en_out = pipe_q.mem_w_en;
  assign alu_res_out  = pipe_q.alu_res;
  assign val_Rm_out   = pipe_q.val_rm;
  assign dest_out     = pipe_q.dest;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Scenario bench for exe_mem_pipe_reg: driven instructions are queued and popped when
// they reach the MEM-side outputs.
module tb_exe_mem_pipe_reg;
  import arm_pkg::*;

  localparam int unsigned TIMEOUT     = 16;
  localparam int unsigned STALL_CNT_W = 32;

  logic                   clk;
  logic                   rst;
  logic                   wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [WORD_W-1:0]      alu_res_in, val_Rm_in;
  logic [REG_ADDR_W-1:0]  dest_in;
  logic                   mem_ready;
  logic                   wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [WORD_W-1:0]      alu_res_out, val_Rm_out;
  logic [REG_ADDR_W-1:0]  dest_out;
  logic                   freeze_out, mem_err, err_sticky;
  logic [STALL_CNT_W-1:0] stall_cycles;

  exe_mem_t exp_q[$];
  exe_mem_t cur;
  int       n_checks = 0;
  int       n_fail   = 0;
  logic [STALL_CNT_W-1:0] exp_stall = '0;

  exe_mem_pipe_reg #(
    .TIMEOUT(TIMEOUT),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in), .dest_in(dest_in),
    .mem_ready(mem_ready),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_res_out(alu_res_out), .val_Rm_out(val_Rm_out), .dest_out(dest_out),
    .freeze_out(freeze_out), .mem_err(mem_err), .err_sticky(err_sticky),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  function automatic exe_mem_t mk(input logic wb, input logic rd, input logic wr,
                                  input logic [31:0] a, input logic [31:0] v,
                                  input logic [3:0] d);
    exe_mem_t t;
    t.wb_en = wb; t.mem_r_en = rd; t.mem_w_en = wr;
    t.alu_res = a; t.val_rm = v; t.dest = d;
    return t;
  endfunction

  function automatic exe_mem_t obs();
    exe_mem_t t;
    t.wb_en = wb_en_out; t.mem_r_en = mem_r_en_out; t.mem_w_en = mem_w_en_out;
    t.alu_res = alu_res_out; t.val_rm = val_Rm_out; t.dest = dest_out;
    return t;
  endfunction

  task automatic feed(input exe_mem_t t);
    wb_en_in = t.wb_en; mem_r_en_in = t.mem_r_en; mem_w_en_in = t.mem_w_en;
    alu_res_in = t.alu_res; val_Rm_in = t.val_rm; dest_in = t.dest;
    exp_q.push_back(t);
  endtask

  task automatic feed_nop();
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    alu_res_in = '0; val_Rm_in = '0; dest_in = '0;
  endtask

  task automatic pop_exp();
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; feed_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs() !== '0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", obs()); end
    n_checks++;
    if ({freeze_out, mem_err, err_sticky} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {freeze_out, mem_err, err_sticky});
    end
    n_checks++;
    if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    feed(mk(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h3));
    mem_ready = 1'b1;
    @(negedge clk);
    tick();
    feed_nop(); pop_exp();
    @(negedge clk);
    n_checks++;
    if (obs() !== cur) begin n_fail++; $display("FAIL alu_out: got %h want %h", obs(), cur); end
    n_checks++;
    if (freeze_out !== 1'b0) begin n_fail++; $display("FAIL alu_freeze: got %b want 0", freeze_out); end
    tick();
  endtask

  task automatic test_nonmem_no_freeze();
    feed(mk(1'b1, 1'b0, 1'b0, 32'h77, 32'h1, 4'h1));
    mem_ready = 1'b0;
    @(negedge clk);
    tick();
    feed_nop(); pop_exp();
    @(negedge clk);
    n_checks++;
    if (obs() !== cur) begin n_fail++; $display("FAIL nonmem_out: got %h want %h", obs(), cur); end
    n_checks++;
    if (freeze_out !== 1'b0) begin n_fail++; $display("FAIL nonmem_freeze: got %b want 0", freeze_out); end
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_load_stall();
    feed(mk(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'h5));
    mem_ready = 1'b1;
    @(negedge clk);
    tick();
    feed_nop(); pop_exp();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs() !== cur) begin n_fail++; $display("FAIL load_hold[%0d]: got %h want %h", i, obs(), cur); end
      n_checks++;
      if (freeze_out !== 1'b1) begin n_fail++; $display("FAIL load_freeze[%0d]: got %b want 1", i, freeze_out); end
      n_checks++;
      if (mem_err !== 1'b0) begin n_fail++; $display("FAIL load_err[%0d]: got %b want 0", i, mem_err); end
      exp_stall++;
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (freeze_out !== 1'b0 || obs() !== cur) begin
      n_fail++; $display("FAIL load_done: freeze %b out %h want 0 %h", freeze_out, obs(), cur);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL load_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
    n_checks++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL load_no_err: got %b want 0", mem_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    feed(mk(1'b0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'h0));
    mem_ready = 1'b1;
    @(negedge clk);
    tick();
    feed(mk(1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 4'h7));
    for (int op = 0; op < 2; op++) begin
      pop_exp();
      for (int i = 0; i < 2; i++) begin
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs() !== cur || freeze_out !== 1'b1) begin
          n_fail++; $display("FAIL b2b_hold[%0d.%0d]: out %h frz %b want %h 1", op, i, obs(), freeze_out, cur);
        end
        exp_stall++;
        tick();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs() !== cur || freeze_out !== 1'b0) begin
        n_fail++; $display("FAIL b2b_done[%0d]: out %h frz %b want %h 0", op, obs(), freeze_out, cur);
      end
      tick();
      feed_nop();
    end
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
    tick();
  endtask

  task automatic test_ready_at_limit();
    feed(mk(1'b1, 1'b1, 1'b0, 32'h800, 32'h0, 4'h9));
    mem_ready = 1'b1;
    @(negedge clk);
    tick();
    feed_nop(); pop_exp();
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs() !== cur || freeze_out !== 1'b1) begin
        n_fail++; $display("FAIL limit_hold[%0d]: out %h frz %b want %h 1", i, obs(), freeze_out, cur);
      end
      exp_stall++;
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wb_en_out !== 1'b1 || freeze_out !== 1'b0) begin
      n_fail++; $display("FAIL limit_complete: wb %b frz %b want 1 0", wb_en_out, freeze_out);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_err !== 1'b0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL limit_no_err: err %b sticky %b want 0 0", mem_err, err_sticky);
    end
    tick();
  endtask

  task automatic test_timeout();
    exe_mem_t ab;
    feed(mk(1'b1, 1'b1, 1'b0, 32'hC00, 32'h0, 4'hA));
    mem_ready = 1'b1;
    @(negedge clk);
    tick();
    feed(mk(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'hB));
    pop_exp();
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs() !== cur || freeze_out !== 1'b1 || mem_err !== 1'b0) begin
        n_fail++; $display("FAIL to_hold[%0d]: out %h frz %b err %b want %h 1 0", i, obs(), freeze_out, mem_err, cur);
      end
      exp_stall++;
      tick();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    ab = cur; ab.wb_en = 1'b0;
    n_checks++;
    if (obs() !== ab) begin n_fail++; $display("FAIL to_abort_out: got %h want %h", obs(), ab); end
    n_checks++;
    if (freeze_out !== 1'b0) begin n_fail++; $display("FAIL to_abort_freeze: got %b want 0", freeze_out); end
    tick();
    feed_nop(); pop_exp();
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_err !== 1'b1 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL to_err: err %b sticky %b want 1 1", mem_err, err_sticky);
    end
    n_checks++;
    if (obs() !== cur) begin n_fail++; $display("FAIL to_next_captured: got %h want %h", obs(), cur); end
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_err !== 1'b0 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL to_pulse: err %b sticky %b want 0 1", mem_err, err_sticky);
    end
    n_checks++;
    if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL to_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
    tick();
  endtask

  task automatic test_reset_mid();
    feed(mk(1'b1, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hC));
    mem_ready = 1'b1;
    @(negedge clk);
    tick();
    feed_nop(); pop_exp();
    mem_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs() !== '0 || freeze_out !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: out %h frz %b want 0 0", obs(), freeze_out);
    end
    n_checks++;
    if ({mem_err, err_sticky} !== 2'b00 || stall_cycles !== '0) begin
      n_fail++; $display("FAIL rstmid_state: err %b sticky %b stall %0d want 0 0 0", mem_err, err_sticky, stall_cycles);
    end
    exp_q.delete();
    exp_stall = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_err !== 1'b0 || stall_cycles !== '0) begin
      n_fail++; $display("FAIL rstmid_release: err %b stall %0d want 0 0", mem_err, stall_cycles);
    end
    tick();
    // A full-length wait after reset must not abort early: wait_cnt restarted from zero.
    feed(mk(1'b1, 1'b1, 1'b0, 32'h1004, 32'h0, 4'hD));
    @(negedge clk);
    tick();
    feed_nop(); pop_exp();
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (freeze_out !== 1'b1 || obs() !== cur) begin
        n_fail++; $display("FAIL rstmid_wait[%0d]: frz %b out %h want 1 %h", i, freeze_out, obs(), cur);
      end
      exp_stall++;
      tick();
    end
    mem_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== exp_stall || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_final: stall %0d err %b want %0d 0", stall_cycles, mem_err, exp_stall);
    end
  endtask

  initial begin
    feed_nop();
    mem_ready = 1'b1;
    rst = 1'b0;
    test_reset();
    test_alu();
    test_nonmem_no_freeze();
    test_load_stall();
    test_back_to_back();
    test_ready_at_limit();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
